axis_packet_tx: RTL and testbench

Transmit-side AXI-Stream packetizer: accepts an unframed DW-bit byte stream and emits it as `k` packets of `len` beats each, asserting `m_tlast` on the final beat of every packet. The block uses the same `packet_config` = {len, k} format as the receive path. It sits between a payload source and the link toward the packet receiver. Output is a registered, one-beat-deep stage, and it reports run status through `busy`, `done` and `pkt_cnt`.

---
 rtl/axis_packet_tx_if.sv | 12 +
 rtl/axis_packet_tx.sv | 77 +++++++
 tb/tb_axis_packet_tx.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/axis_packet_tx_if.sv
// axis_packet_tx_if: payload-in and packet-out stream signals of the packetizer
interface axis_packet_tx_if #(parameter int DW = 8);
   logic [DW-1:0] s_tdata;
   logic          s_tvalid;
   logic          s_tready;
   logic [DW-1:0] m_tdata;
   logic          m_tvalid;
   logic          m_tlast;
   logic          m_tready;
   modport slave (input s_tdata, s_tvalid, m_tready, output s_tready, m_tdata, m_tvalid, m_tlast);
   modport master (output s_tdata, s_tvalid, m_tready, input s_tready, m_tdata, m_tvalid, m_tlast);
endinterface

// File: rtl/axis_packet_tx.sv
// axis_packet_tx: frames an unframed byte stream into k packets of len beats through a one-deep output register
module axis_packet_tx #(parameter int DW = 8) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [2*DW-1:0]     packet_config,
   axis_packet_tx_if.slave     bus,
   output logic                busy,
   output logic                done,
   output logic [DW-1:0]       pkt_cnt
);
   localparam logic [DW-1:0] ONE = DW'(1);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
   state_t state, state_nx;
   logic [DW-1:0] len_r, k_r, beat_cnt, in_pkt, cfg_len, cfg_k;
   logic cfg_ok, accept, in_hs, out_hs, last_beat, last_pkt, done_nx;
   assign cfg_len = packet_config[2*DW-1:DW];
   assign cfg_k = packet_config[DW-1:0];
   assign cfg_ok = |cfg_len && |cfg_k;
   assign accept = state == IDLE && start && cfg_ok;
   assign last_beat = beat_cnt == len_r - ONE;
   assign last_pkt = in_pkt == k_r - ONE;
   assign bus.s_tready = state == RUN && (!bus.m_tvalid || bus.m_tready);
   assign in_hs = bus.s_tvalid && bus.s_tready;
   assign out_hs = bus.m_tvalid && bus.m_tready;
   assign busy = state != IDLE;
   always_ff @(posedge clk)
      if (rst) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = state;
      done_nx = 1'b0;
      case (state)
         IDLE: begin
            state_nx = accept ? RUN : IDLE;
            done_nx = start && !cfg_ok;
         end
         RUN: state_nx = in_hs && last_beat && last_pkt ? DRAIN : RUN;
         DRAIN: begin
            state_nx = out_hs ? IDLE : DRAIN;
            done_nx = out_hs;
         end
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         len_r <= '0;
         k_r <= '0;
         beat_cnt <= '0;
         in_pkt <= '0;
         pkt_cnt <= '0;
         done <= 1'b0;
         bus.m_tdata <= '0;
         bus.m_tvalid <= 1'b0;
         bus.m_tlast <= 1'b0;
      end else begin
         done <= done_nx;
         if (accept) begin
            len_r <= cfg_len;
            k_r <= cfg_k;
            beat_cnt <= '0;
            in_pkt <= '0;
            pkt_cnt <= '0;
         end
         if (in_hs) begin
            bus.m_tdata <= bus.s_tdata;
            bus.m_tlast <= last_beat;
            beat_cnt <= last_beat ? '0 : beat_cnt + ONE;
            in_pkt <= last_beat ? in_pkt + ONE : in_pkt;
         end
         // a loaded beat wins over the drain, otherwise hold until accepted
         bus.m_tvalid <= in_hs || (bus.m_tvalid && !bus.m_tready);
         if (out_hs && bus.m_tlast) pkt_cnt <= pkt_cnt + ONE;
      end
   end
endmodule

// File: tb/tb_axis_packet_tx.sv
// tb_axis_packet_tx: directed and randomized runs of axis_packet_tx against a queue-based packet model
module tb_axis_packet_tx;
   localparam int DW = 8;
   logic clk = 1'b0;
   logic rst, start, busy, done;
   logic [2*DW-1:0] packet_config;
   logic [DW-1:0] pkt_cnt;
   int checks = 0;
   int fails = 0;
   axis_packet_tx_if #(.DW(DW)) ifc ();
   axis_packet_tx #(.DW(DW)) dut (
      .clk(clk), .rst(rst), .start(start), .packet_config(packet_config),
      .bus(ifc), .busy(busy), .done(done), .pkt_cnt(pkt_cnt)
   );
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic rand_inputs();
      ifc.s_tvalid = 1'($urandom);
      ifc.s_tdata = 8'($urandom);
      ifc.m_tready = 1'($urandom);
   endtask

   task automatic do_start(input int len, input int k);
      start = 1'b1;
      packet_config = {len[7:0], k[7:0]};
      @(posedge clk); #1;
      start = 1'b0;
      packet_config = 16'($urandom);
   endtask

   task automatic run(input int len, input int k, input int vp, input int rp, input bit seq, input bit poke);
      logic [8:0] q[$];
      logic [7:0] d, pd;
      logic pl;
      bit stall;
      int total, idx, outn, pk, cyc;
      total = len * k;
      idx = 0; outn = 0; pk = 0; cyc = 0; stall = 0; pd = '0; pl = 1'b0;
      for (int i = 0; i < total; i++) begin
         d = seq ? 8'(i + 1) : 8'($urandom);
         q.push_back({(i % len) == len - 1, d});
      end
      do_start(len, k);
      while (outn < total && cyc < 20000) begin
         ifc.s_tvalid = $urandom_range(99) < vp;
         ifc.s_tdata = idx < total ? q[idx][7:0] : 8'($urandom);
         ifc.m_tready = $urandom_range(99) < rp;
         start = poke && cyc == 3;
         if (start) packet_config = 16'h0101;
         @(negedge clk);
         chk("busy_run", busy, 1);
         chk("done_run", done, 0);
         chk("pkt_cnt_run", pkt_cnt, pk);
         if (stall) begin
            chk("hold_data", ifc.m_tdata, pd);
            chk("hold_last", ifc.m_tlast, pl);
         end
         if (ifc.m_tvalid && !ifc.m_tready) chk("s_tready_bp", ifc.s_tready, 0);
         if (idx == total) chk("s_tready_drain", ifc.s_tready, 0);
         if (vp == 100 && rp == 100 && cyc > 0) chk("throughput", ifc.m_tvalid, 1);
         if (ifc.m_tvalid && ifc.m_tready) begin
            chk("m_tdata", ifc.m_tdata, q[outn][7:0]);
            chk("m_tlast", ifc.m_tlast, q[outn][8]);
            pk += int'(q[outn][8]);
            outn++;
         end
         stall = ifc.m_tvalid && !ifc.m_tready;
         pd = ifc.m_tdata;
         pl = ifc.m_tlast;
         if (ifc.s_tvalid && ifc.s_tready) idx++;
         @(posedge clk); #1;
         cyc++;
      end
      start = 1'b0;
      chk("beats_out", outn, total);
      @(negedge clk);
      chk("done_pulse", done, 1);
      chk("busy_end", busy, 0);
      chk("pkt_cnt_end", pkt_cnt, k);
      chk("m_tvalid_end", ifc.m_tvalid, 0);
      chk("s_tready_end", ifc.s_tready, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("done_single", done, 0);
      chk("pkt_cnt_hold", pkt_cnt, k);
      @(posedge clk); #1;
   endtask

   task automatic degen(input int len, input int k);
      ifc.s_tvalid = 1'b1;
      do_start(len, k);
      @(negedge clk);
      chk("degen_done", done, 1);
      chk("degen_busy", busy, 0);
      chk("degen_m_tvalid", ifc.m_tvalid, 0);
      chk("degen_s_tready", ifc.s_tready, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("degen_done_low", done, 0);
      chk("degen_busy_low", busy, 0);
      chk("degen_no_beat", ifc.m_tvalid, 0);
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b1;
      start = 1'($urandom);
      packet_config = 16'($urandom);
      rand_inputs();
      repeat (2) begin
         @(posedge clk); #1;
         start = 1'($urandom);
         packet_config = 16'($urandom);
         rand_inputs();
      end
      @(negedge clk);
      chk("rst_s_tready", ifc.s_tready, 0);
      chk("rst_m_tvalid", ifc.m_tvalid, 0);
      chk("rst_m_tlast", ifc.m_tlast, 0);
      chk("rst_m_tdata", ifc.m_tdata, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_pkt_cnt", pkt_cnt, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      start = 1'b0;
      run(4, 2, 100, 100, 1, 0);
      run(4, 2, 60, 50, 1, 0);
      run(1, 3, 100, 100, 0, 0);
      run(255, 1, 100, 100, 0, 0);
      degen(0, 5);
      degen(3, 0);
      run(4, 2, 70, 40, 0, 1);
      do_start(4, 2);
      ifc.s_tvalid = 1'b1;
      ifc.m_tready = 1'b1;
      ifc.s_tdata = 8'h11;
      @(posedge clk); #1;
      ifc.s_tdata = 8'h22;
      @(posedge clk); #1;
      ifc.s_tvalid = 1'b0;
      ifc.m_tready = 1'b0;
      @(negedge clk);
      chk("mid_m_tvalid", ifc.m_tvalid, 1);
      chk("mid_m_tdata", ifc.m_tdata, 8'h22);
      @(posedge clk); #1;
      rst = 1'b1;
      start = 1'b1;
      packet_config = 16'h0301;
      @(posedge clk); #1;
      rst = 1'b0;
      start = 1'b0;
      @(negedge clk);
      chk("mid_rst_m_tvalid", ifc.m_tvalid, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_pkt_cnt", pkt_cnt, 0);
      @(posedge clk); #1;
      run(2, 1, 80, 80, 0, 0);
      repeat (4) run($urandom_range(1, 12), $urandom_range(1, 4), $urandom_range(30, 100), $urandom_range(30, 100), 0, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
